// File: rtl/uart_receiver_param.sv
// rtl/uart_receiver_param.sv - oversampling UART receiver with configurable width, parity and stop bits
module uart_receiver_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state;
    logic                 r_sync;
    logic                 r_rx_s;
    logic                 r_rx_p;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr_pend;
    logic                 r_ferr_pend;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sync      <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_p      <= 1'b1;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync <= rx;
            r_rx_s <= r_sync;
            r_rx_p <= r_rx_s;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Edge-triggered start: a line stuck low never re-arms a frame
                    if (r_rx_p && !r_rx_s) begin
                        r_tick      <= '0;
                        r_perr_pend <= 1'b0;
                        r_ferr_pend <= 1'b0;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_busy <= 1'b1;
                    if (s_tick) begin
                        if (r_tick == TICK_MID) begin
                            if (!r_rx_s) begin
                                r_tick  <= '0;
                                r_bit   <= '0;
                                r_state <= S_DATA;
                            end else begin
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                S_DATA: begin
                    if (s_tick) begin
                        if (r_tick == TICK_LAST) begin
                            r_tick  <= '0;
                            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            if (r_bit == BIT_LAST) begin
                                r_bit   <= '0;
                                r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (s_tick) begin
                        if (r_tick == TICK_LAST) begin
                            r_tick      <= '0;
                            r_perr_pend <= ((^r_shift) ^ r_rx_s) != ODD;
                            r_state     <= S_STOP;
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                S_STOP: begin
                    if (s_tick) begin
                        if (r_tick == TICK_LAST) begin
                            r_tick <= '0;
                            // Finish at mid stop bit so a back-to-back start edge is caught
                            if (r_bit == STOP_LAST) begin
                                r_data  <= r_shift;
                                r_perr  <= (PARITY_EN != 0) && r_perr_pend;
                                r_ferr  <= r_ferr_pend | ~r_rx_s;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_bit   <= '0;
                                r_state <= S_IDLE;
                            end else begin
                                r_ferr_pend <= r_ferr_pend | ~r_rx_s;
                                r_bit       <= r_bit + BW'(1);
                            end
                        end else begin
                            r_tick <= r_tick + TW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rx_data    = r_data;
    assign rx_done    = r_done;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign rx_busy    = r_busy;
endmodule

// File: tb/tb_uart_receiver_param.sv
// tb/tb_uart_receiver_param.sv - randomized bench for three uart_receiver_param configurations
module tb_uart_receiver_param;
    localparam int BITCLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_tick = 1'b0;
    logic [2:0] rx_l = 3'b111;
    logic [2:0] w_done, w_perr, w_ferr, w_busy;
    logic [7:0] w_data0, w_data2;
    logic [6:0] w_data1;

    int total = 0;
    int bad = 0;
    int tdiv = 0;
    int done_cnt[3] = '{0, 0, 0};
    bit busy_seen[3] = '{0, 0, 0};
    int cfg_db[3]  = '{8, 7, 8};
    int cfg_pe[3]  = '{0, 1, 0};
    int cfg_odd[3] = '{0, 0, 0};
    int cfg_sb[3]  = '{1, 1, 2};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tdiv == 3) begin
            tdiv   <= 0;
            s_tick <= 1'b1;
        end else begin
            tdiv   <= tdiv + 1;
            s_tick <= 1'b0;
        end
    end

    uart_receiver_param u0 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[0]), .rx_data(w_data0),
        .rx_done(w_done[0]), .parity_err(w_perr[0]), .frame_err(w_ferr[0]), .rx_busy(w_busy[0])
    );
    uart_receiver_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[1]), .rx_data(w_data1),
        .rx_done(w_done[1]), .parity_err(w_perr[1]), .frame_err(w_ferr[1]), .rx_busy(w_busy[1])
    );
    uart_receiver_param #(.STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[2]), .rx_data(w_data2),
        .rx_done(w_done[2]), .parity_err(w_perr[2]), .frame_err(w_ferr[2]), .rx_busy(w_busy[2])
    );

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_done[i]) done_cnt[i]++;
            if (w_busy[i]) busy_seen[i] = 1'b1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] get_data(input int idx);
        case (idx)
            0:       return {1'b0, w_data0};
            1:       return {2'b0, w_data1};
            default: return {1'b0, w_data2};
        endcase
    endfunction

    // Expected frame result from what was put on the wire
    function automatic void model(input int idx, input logic [8:0] word, input logic pbit,
                                  input logic [1:0] stops, output logic [8:0] ed,
                                  output logic ep, output logic ef);
        int ones;
        ed   = word & 9'((1 << cfg_db[idx]) - 1);
        ones = $countones(ed) + int'(pbit);
        ep   = (cfg_pe[idx] != 0) && ((ones % 2) != cfg_odd[idx]);
        ef   = !stops[0] || (cfg_sb[idx] == 2 && !stops[1]);
    endfunction

    task automatic drive(input int idx, input logic v, input int n);
        rx_l[idx] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] word, input logic pbit,
                              input logic [1:0] stops);
        int c0;
        logic [8:0] ed;
        logic ep, ef;
        c0 = done_cnt[idx];
        drive(idx, 1'b0, BITCLK);
        for (int b = 0; b < cfg_db[idx]; b++) drive(idx, word[b], BITCLK);
        if (cfg_pe[idx] != 0) drive(idx, pbit, BITCLK);
        if (cfg_sb[idx] == 2) drive(idx, stops[0], BITCLK);
        check_val("no_early_done", done_cnt[idx] - c0, 0);
        drive(idx, stops[cfg_sb[idx]-1], BITCLK);
        check_val("one_done", done_cnt[idx] - c0, 1);
        model(idx, word, pbit, stops, ed, ep, ef);
        check_val("rx_data", get_data(idx), ed);
        check_val("parity_err", w_perr[idx], ep);
        check_val("frame_err", w_ferr[idx], ef);
        if (!stops[cfg_sb[idx]-1]) drive(idx, 1'b1, BITCLK);
    endtask

    initial begin
        logic [8:0] d0, ed;
        logic ep, ef, pb;
        logic [1:0] st;
        int c0;

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val("rst_data", get_data(i), 0);
            check_val("rst_done", w_done[i], 0);
            check_val("rst_perr", w_perr[i], 0);
            check_val("rst_ferr", w_ferr[i], 0);
            check_val("rst_busy", w_busy[i], 0);
        end
        rst = 1'b0;
        repeat (BITCLK) @(negedge clk);

        send_frame(0, 9'h0A5, 1'b0, 2'b11);
        send_frame(0, 9'h03C, 1'b0, 2'b11);
        send_frame(1, 9'h055, 1'b0, 2'b11);
        send_frame(1, 9'h055, 1'b1, 2'b11);
        send_frame(2, 9'h0FF, 1'b0, 2'b01);
        send_frame(2, 9'h012, 1'b0, 2'b11);

        // glitch: 3 ticks low must not produce a frame
        d0 = get_data(0);
        c0 = done_cnt[0];
        busy_seen[0] = 1'b0;
        drive(0, 1'b0, 12);
        drive(0, 1'b1, 2 * BITCLK);
        check_val("glitch_busy", busy_seen[0], 1);
        check_val("glitch_done", done_cnt[0] - c0, 0);
        check_val("glitch_data", get_data(0), d0);
        check_val("glitch_busy_end", w_busy[0], 0);

        // break: three frame times low gives exactly one frame
        c0 = done_cnt[0];
        drive(0, 1'b0, 30 * BITCLK);
        model(0, 9'h000, 1'b0, 2'b00, ed, ep, ef);
        check_val("break_done", done_cnt[0] - c0, 1);
        check_val("break_data", get_data(0), ed);
        check_val("break_ferr", w_ferr[0], ef);
        drive(0, 1'b1, BITCLK);
        send_frame(0, 9'h081, 1'b0, 2'b11);

        // reset during data bit 4 of 0xC3, held until the line is high again
        c0 = done_cnt[0];
        drive(0, 1'b0, BITCLK);
        for (int b = 0; b < 4; b++) drive(0, 9'h0C3 >> b & 1, BITCLK);
        rx_l[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_data", get_data(0), 0);
        check_val("mid_rst_done", w_done[0], 0);
        check_val("mid_rst_perr", w_perr[0], 0);
        check_val("mid_rst_ferr", w_ferr[0], 0);
        check_val("mid_rst_busy", w_busy[0], 0);
        drive(0, 1'b0, 2 * BITCLK - 1);
        rx_l[0] = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 3 * BITCLK);
        check_val("mid_rst_no_done", done_cnt[0] - c0, 0);
        send_frame(0, 9'h05A, 1'b0, 2'b11);

        for (int k = 0; k < 8; k++) begin
            for (int idx = 0; idx < 3; idx++) begin
                pb = 1'($urandom_range(0, 1));
                st[0] = ($urandom_range(0, 3) != 0);
                st[1] = ($urandom_range(0, 3) != 0);
                send_frame(idx, 9'($urandom), pb, st);
                drive(idx, 1'b1, $urandom_range(0, 40));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_receiver_param.md
# uart_receiver_param

Parametrised oversampling UART receiver with its own datapath and control. It sits between the asynchronous `rx` pin and the host logic, sharing the baud-rate generator's `s_tick` with the transmitter. Over the fixed 8N1 receiver it adds configurable data width, oversampling ratio, optional even/odd parity, 1 or 2 stop bits, an input synchroniser, false-start rejection and per-frame parity and framing error flags.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit period; must be even and at least 8.
- `PARITY_EN`, 0: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, 0: 1 selects odd parity, 0 selects even; ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `s_tick`  in  1  oversampling enable, one `clk` wide.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  DATA_BITS  last received word, LSB = first bit received.
- `rx_done`  out  1  one-`clk` pulse marking a completed frame.
- `parity_err`  out  1  parity mismatch in the last frame.
- `frame_err`  out  1  a stop bit was sampled low in the last frame.
- `rx_busy`  out  1  high when the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`), followed by a history flop (`rx_p`). Both reset to 1.
- The tick counter is `$clog2(OVERSAMPLE)` bits wide and advances only on `s_tick`. The bit counter is `$clog2(DATA_BITS+1)` bits wide.
- The FSM has five states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - A falling edge (`rx_p`=1, `rx_s`=0) clears the tick counter and moves to START.
  - A level-low line does not start a frame. A break therefore yields exactly one frame.
- **START**
  - On the `s_tick` where count = `OVERSAMPLE/2-1` (mid start bit):
    - if `rx_s`=0, clear the tick and bit counters and go to DATA;
    - if `rx_s`=1, treat it as a glitch: return to IDLE with no `rx_done` and all outputs unchanged.
  - Otherwise increment the tick counter on `s_tick`.
- **DATA**
  - On the `s_tick` where count = `OVERSAMPLE-1`, clear the counter and shift `rx_s` into the MSB of the shift register (right shift). Increment the bit counter.
  - After the `DATA_BITS`-th sample, go to PARITY if `PARITY_EN`=1, else to STOP.
- **PARITY**
  - Sample at count = `OVERSAMPLE-1`.
  - Pending parity error = (XOR of data bits ^ sampled bit) != `PARITY_ODD`.
  - Go to STOP.
- **STOP**
  - Sample at count = `OVERSAMPLE-1` for each of `STOP_BITS` bits. Any low sample sets the pending framing error.
  - On the last stop-bit sample, load `rx_data`, `parity_err` and `frame_err` from the pending values, pulse `rx_done`, and go to IDLE.
  - Exit happens at mid stop bit, so the next start edge is never missed.
- Pending error flags clear when START is entered. `parity_err` is always 0 when `PARITY_EN`=0.
- Outputs hold their values until the next `rx_done`. A frame with errors still updates `rx_data`.

## Timing
- **Reset** (synchronous, dominates `s_tick` and `rx`) forces:
  - state IDLE and all counters 0;
  - `rx_data`=0, `rx_done`=0, `parity_err`=0, `frame_err`=0, `rx_busy`=0;
  - `rx_s`=`rx_p`=1.
- **Reset mid-frame** aborts the frame with no `rx_done`. The next frame needs a fresh falling edge.
- **Pin to IDLE exit:** 3 `clk` from a `rx` fall to the START transition (2 sync stages plus the edge flop).
- **Frame length:** `rx_done` rises `OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS + PARITY_EN + STOP_BITS) - 1` `s_tick`s after the first START tick, in the `clk` after that tick's edge.
- **`rx_done` output:** registered, high for exactly 1 `clk`. `rx_data` and the flags become valid in the same cycle.
- **`rx_busy`:** registered from state. It rises 1 `clk` after the IDLE→START edge and falls in the `rx_done` cycle.
- **Tolerance:** with `OVERSAMPLE`=16, a clean frame is received with up to ±4% baud mismatch.

## Test plan
- **Defaults (8N1, OVERSAMPLE=16, `s_tick` every 4 `clk`):** send 0xA5 then 0x3C back-to-back → two `rx_done` pulses, `rx_data`=0xA5 then 0x3C, both error flags 0, no frame lost.
- **`DATA_BITS`=7, `PARITY_EN`=1, `PARITY_ODD`=0:**
  - send 0x55 with parity bit 0 → `rx_data`=0x55, `parity_err`=0;
  - resend with parity bit 1 → `parity_err`=1, `rx_data`=0x55.
- **`STOP_BITS`=2:** second stop bit driven low on 0xFF → `frame_err`=1, `rx_data`=0xFF. The next clean frame clears `frame_err` to 0.
- **Glitch:** drive `rx` low for 3 `s_tick`s, then high → `rx_busy` pulses, no `rx_done`, outputs unchanged.
- **Break:** hold `rx` low for 3 frame times → exactly one `rx_done` with `rx_data`=0x00 and `frame_err`=1. Releasing high and sending 0x81 → `rx_data`=0x81, `frame_err`=0.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xC3 → all outputs 0 at once, no `rx_done`. A subsequent 0x5A is received correctly.
